// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    LOAD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] PC_INCR = 32'd4;

  // Byte address to memory word address ({2'b00, addr[31:2]}).
  function automatic logic [31:0] word_addr(input logic [31:0] byteAddr);
    return byteAddr >> 2;
  endfunction

endpackage

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer for a synchronous single-read-port memory.
// One address per cycle, stall replay without a skid buffer, redirects,
// and an optional boot-time loader that borrows the memory port.
// Build option: FETCH_LOADER_EN enables the LOAD state and loader ports.
//
// state | meaning
// ------+--------------------------------------------------------------
// BOOT  | first cycle after reset release; issues RESET_PC
// RUN   | normal fetch: redirect > load entry > stall replay > sequential
// LOAD  | loader owns the port; fetch resumes at resumePc on release
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirectValid,
  input  logic [31:0] redirectTarget,
  output logic [31:0] memAddress,
  input  logic [31:0] memReadData,
  output logic        memWriteEnable,
  output logic [31:0] memWriteData,
  output logic [31:0] instructionOut,
  output logic [31:0] pcOut,
  output logic        instructionValid,
  input  logic        loadReq,
  input  logic [31:0] loadAddress,
  input  logic [31:0] loadData,
  output logic        loadGrant
);

  fetch_state_e state, stateNext;
  logic [31:0]  respPc, respPcNext;
  logic         respValid, respValidNext;
  logic [31:0]  nextPc, nextPcNext;
  logic [31:0]  issuePc;
  logic [31:0]  redirectPc;
  logic         loading;

`ifdef FETCH_LOADER_EN
  logic [31:0]  resumePc, resumePcNext;
`endif

  assign redirectPc = redirectTarget & ~32'h3;

  // Next-state, issue-PC selection and response bookkeeping.
  always_comb begin
    stateNext     = state;
    respPcNext    = respPc;
    respValidNext = respValid;
    nextPcNext    = nextPc;
    issuePc       = nextPc;
    loading       = 1'b0;
`ifdef FETCH_LOADER_EN
    resumePcNext  = resumePc;
`endif
    case (state)
      BOOT: begin
        issuePc       = RESET_PC;
        respPcNext    = RESET_PC;
        respValidNext = 1'b1;
        nextPcNext    = RESET_PC;
        stateNext     = RUN;
`ifdef FETCH_LOADER_EN
        if (loadReq) begin
          stateNext    = LOAD;
          resumePcNext = RESET_PC;
        end
`endif
      end
      RUN: begin
        if (redirectValid) begin
          issuePc = redirectPc;
        end
`ifdef FETCH_LOADER_EN
        else if (loadReq) begin
          // The presented instruction is dropped and refetched on resume.
          issuePc       = respValid ? respPc : nextPc;
          resumePcNext  = issuePc;
          respValidNext = 1'b0;
          stateNext     = LOAD;
        end
`endif
        else if (stall && respValid) begin
          issuePc = respPc;
        end else if (respValid) begin
          issuePc = respPc + PC_INCR;
        end else begin
          issuePc = nextPc;
        end
        if (stateNext == RUN) begin
          respPcNext    = issuePc;
          respValidNext = 1'b1;
          nextPcNext    = issuePc;
        end
      end
`ifdef FETCH_LOADER_EN
      LOAD: begin
        issuePc = resumePc;
        if (loadReq) begin
          loading = 1'b1;
          if (redirectValid) begin
            resumePcNext = redirectPc;
          end
        end else begin
          // A redirect coinciding with the release still wins.
          issuePc       = redirectValid ? redirectPc : resumePc;
          respPcNext    = issuePc;
          respValidNext = 1'b1;
          nextPcNext    = issuePc;
          stateNext     = RUN;
        end
      end
`endif
      default: begin
        issuePc   = RESET_PC;
        stateNext = BOOT;
      end
    endcase
  end

  // State and response registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= BOOT;
      respPc    <= RESET_PC;
      respValid <= 1'b0;
      nextPc    <= RESET_PC;
    end else begin
      state     <= stateNext;
      respPc    <= respPcNext;
      respValid <= respValidNext;
      nextPc    <= nextPcNext;
    end
  end

`ifdef FETCH_LOADER_EN
  // Resume point held across a loader session.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      resumePc <= RESET_PC;
    end else begin
      resumePc <= resumePcNext;
    end
  end

  assign memAddress     = loading ? word_addr(loadAddress) : word_addr(issuePc);
  assign memWriteEnable = loading;
  assign memWriteData   = loading ? loadData : 32'h0;
  assign loadGrant      = loading;

  logic unused_load;
  assign unused_load = ^loadAddress[1:0];
`else
  assign memAddress     = word_addr(issuePc);
  assign memWriteEnable = 1'b0;
  assign memWriteData   = 32'h0;
  assign loadGrant      = 1'b0;

  logic unused_load;
  assign unused_load = ^{loadReq, loadAddress, loadData, loading};
`endif

  assign instructionOut   = memReadData;
  assign pcOut            = respPc;
  assign instructionValid = respValid && (state == RUN) && !redirectValid;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a small synchronous memory.
// Loader scenarios follow the FETCH_LOADER_EN build option.
module tb_fetch_controller;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        redirectValid;
  logic [31:0] redirectTarget;
  logic [31:0] memAddress;
  logic [31:0] memReadData;
  logic        memWriteEnable;
  logic [31:0] memWriteData;
  logic [31:0] instructionOut;
  logic [31:0] pcOut;
  logic        instructionValid;
  logic        loadReq;
  logic [31:0] loadAddress;
  logic [31:0] loadData;
  logic        loadGrant;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [256];

  fetch_controller #(.RESET_PC(32'h0000_0000)) dut (
    .clock           (clock),
    .reset           (reset),
    .stall           (stall),
    .redirectValid   (redirectValid),
    .redirectTarget  (redirectTarget),
    .memAddress      (memAddress),
    .memReadData     (memReadData),
    .memWriteEnable  (memWriteEnable),
    .memWriteData    (memWriteData),
    .instructionOut  (instructionOut),
    .pcOut           (pcOut),
    .instructionValid(instructionValid),
    .loadReq         (loadReq),
    .loadAddress     (loadAddress),
    .loadData        (loadData),
    .loadGrant       (loadGrant)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + i;
  end

  // Synchronous memory: word i initially holds A000_0000 + i.
  always @(posedge clock) begin
    if (memWriteEnable) mem[memAddress[7:0]] <= memWriteData;
    memReadData <= mem[memAddress[7:0]];
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (instructionValid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", instructionValid); end
    checks++; if (loadGrant !== 1'b0) begin errors++; $display("FAIL rst_grant got %b want 0", loadGrant); end
    checks++; if (memWriteEnable !== 1'b0) begin errors++; $display("FAIL rst_we got %b want 0", memWriteEnable); end
    checks++; if (memAddress !== 32'h0) begin errors++; $display("FAIL rst_addr got %h want 0", memAddress); end
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++; if (instructionValid !== 1'b0) begin errors++; $display("FAIL boot_valid got %b want 0", instructionValid); end
    checks++; if (memAddress !== 32'h0) begin errors++; $display("FAIL boot_addr got %h want 0", memAddress); end
  endtask

  task automatic test_fetch();
    tick(); #1;
    checks++; if (instructionValid !== 1'b1) begin errors++; $display("FAIL seq0_valid got %b want 1", instructionValid); end
    checks++; if (pcOut !== 32'h0) begin errors++; $display("FAIL seq0_pc got %h want 0", pcOut); end
    checks++; if (instructionOut !== 32'hA000_0000) begin errors++; $display("FAIL seq0_instr got %h want a0000000", instructionOut); end
    checks++; if (memAddress !== 32'h1) begin errors++; $display("FAIL seq0_addr got %h want 1", memAddress); end
    tick(); #1;
    checks++; if (pcOut !== 32'h4) begin errors++; $display("FAIL seq1_pc got %h want 4", pcOut); end
    checks++; if (instructionOut !== 32'hA000_0001) begin errors++; $display("FAIL seq1_instr got %h want a0000001", instructionOut); end
    checks++; if (memAddress !== 32'h2) begin errors++; $display("FAIL seq1_addr got %h want 2", memAddress); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      tick();
      stall = 1'b1;
      #1;
      checks++; if (instructionValid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %b want 1", i, instructionValid); end
      checks++; if (pcOut !== 32'h8) begin errors++; $display("FAIL stall_pc[%0d] got %h want 8", i, pcOut); end
      checks++; if (instructionOut !== 32'hA000_0002) begin errors++; $display("FAIL stall_instr[%0d] got %h want a0000002", i, instructionOut); end
      checks++; if (memAddress !== 32'h2) begin errors++; $display("FAIL stall_addr[%0d] got %h want 2", i, memAddress); end
    end
    tick();
    stall = 1'b0;
    #1;
    checks++; if (pcOut !== 32'h8 || instructionValid !== 1'b1) begin errors++; $display("FAIL release_pc got %h/%b want 8/1", pcOut, instructionValid); end
    checks++; if (memAddress !== 32'h3) begin errors++; $display("FAIL release_addr got %h want 3", memAddress); end
    tick(); #1;
    checks++; if (pcOut !== 32'hC || instructionValid !== 1'b1) begin errors++; $display("FAIL after_stall_pc got %h/%b want c/1", pcOut, instructionValid); end
    checks++; if (instructionOut !== 32'hA000_0003) begin errors++; $display("FAIL after_stall_instr got %h want a0000003", instructionOut); end
  endtask

  task automatic test_redirect();
    tick();
    stall = 1'b1;
    redirectValid = 1'b1;
    redirectTarget = 32'h0000_0102;
    #1;
    checks++; if (instructionValid !== 1'b0) begin errors++; $display("FAIL redir_valid got %b want 0", instructionValid); end
    checks++; if (memAddress !== 32'h40) begin errors++; $display("FAIL redir_addr got %h want 40", memAddress); end
    tick();
    redirectValid = 1'b0;
    #1;
    checks++; if (instructionValid !== 1'b1) begin errors++; $display("FAIL redir_tgt_valid got %b want 1", instructionValid); end
    checks++; if (pcOut !== 32'h100) begin errors++; $display("FAIL redir_tgt_pc got %h want 100", pcOut); end
    checks++; if (instructionOut !== 32'hA000_0040) begin errors++; $display("FAIL redir_tgt_instr got %h want a0000040", instructionOut); end
    checks++; if (memAddress !== 32'h40) begin errors++; $display("FAIL redir_replay_addr got %h want 40", memAddress); end
    tick();
    stall = 1'b0;
    #1;
    checks++; if (pcOut !== 32'h100 || memAddress !== 32'h41) begin errors++; $display("FAIL redir_release got pc %h addr %h want 100/41", pcOut, memAddress); end
    tick(); #1;
    checks++; if (pcOut !== 32'h104 || instructionOut !== 32'hA000_0041) begin errors++; $display("FAIL redir_next got %h/%h want 104/a0000041", pcOut, instructionOut); end
  endtask

  task automatic test_back_to_back();
    tick();
    redirectValid = 1'b1;
    redirectTarget = 32'h0000_0020;
    #1;
    checks++; if (instructionValid !== 1'b0 || memAddress !== 32'h8) begin errors++; $display("FAIL b2b_first got %b/%h want 0/8", instructionValid, memAddress); end
    tick();
    redirectTarget = 32'h0000_0044;
    #1;
    checks++; if (instructionValid !== 1'b0 || memAddress !== 32'h11) begin errors++; $display("FAIL b2b_second got %b/%h want 0/11", instructionValid, memAddress); end
    tick();
    redirectValid = 1'b0;
    #1;
    checks++; if (pcOut !== 32'h44 || instructionValid !== 1'b1) begin errors++; $display("FAIL b2b_pc got %h/%b want 44/1", pcOut, instructionValid); end
    checks++; if (instructionOut !== 32'hA000_0011 || memAddress !== 32'h12) begin errors++; $display("FAIL b2b_instr got %h/%h want a0000011/12", instructionOut, memAddress); end
  endtask

  task automatic test_wrap();
    tick();
    redirectValid = 1'b1;
    redirectTarget = 32'hFFFF_FFFF;
    #1;
    checks++; if (memAddress !== 32'h3FFF_FFFF) begin errors++; $display("FAIL wrap_issue got %h want 3fffffff", memAddress); end
    tick();
    redirectValid = 1'b0;
    #1;
    checks++; if (pcOut !== 32'hFFFF_FFFC || instructionOut !== 32'hA000_00FF) begin errors++; $display("FAIL wrap_top got %h/%h want fffffffc/a00000ff", pcOut, instructionOut); end
    checks++; if (memAddress !== 32'h0) begin errors++; $display("FAIL wrap_addr got %h want 0", memAddress); end
    tick(); #1;
    checks++; if (pcOut !== 32'h0 || instructionValid !== 1'b1) begin errors++; $display("FAIL wrap_pc got %h/%b want 0/1", pcOut, instructionValid); end
    checks++; if (instructionOut !== 32'hA000_0000 || memAddress !== 32'h1) begin errors++; $display("FAIL wrap_instr got %h/%h want a0000000/1", instructionOut, memAddress); end
  endtask

`ifdef FETCH_LOADER_EN
  task automatic test_loader();
    logic [31:0] expData;
    tick();
    redirectValid = 1'b1;
    redirectTarget = 32'h0000_0010;
    #1;
    tick();
    redirectValid = 1'b0;
    loadReq = 1'b1;
    #1;
    checks++; if (pcOut !== 32'h10 || loadGrant !== 1'b0 || memWriteEnable !== 1'b0) begin errors++; $display("FAIL load_entry got pc %h grant %b we %b want 10/0/0", pcOut, loadGrant, memWriteEnable); end
    for (int i = 0; i < 4; i++) begin
      tick();
      loadAddress = 32'h10 + 32'(4 * i);
      loadData = 32'hB0 + 32'(i);
      expData = 32'hB0 + 32'(i);
      #1;
      checks++; if (loadGrant !== 1'b1 || memWriteEnable !== 1'b1) begin errors++; $display("FAIL load_grant[%0d] got %b/%b want 1/1", i, loadGrant, memWriteEnable); end
      checks++; if (instructionValid !== 1'b0) begin errors++; $display("FAIL load_valid[%0d] got %b want 0", i, instructionValid); end
      checks++; if (memAddress !== 32'h4 + 32'(i) || memWriteData !== expData) begin errors++; $display("FAIL load_write[%0d] got %h/%h want %h/%h", i, memAddress, memWriteData, 32'h4 + 32'(i), expData); end
    end
    tick();
    loadReq = 1'b0;
    #1;
    checks++; if (loadGrant !== 1'b0 || memWriteEnable !== 1'b0 || instructionValid !== 1'b0) begin errors++; $display("FAIL load_exit got %b/%b/%b want 0/0/0", loadGrant, memWriteEnable, instructionValid); end
    checks++; if (memAddress !== 32'h4) begin errors++; $display("FAIL load_resume_addr got %h want 4", memAddress); end
    tick(); #1;
    checks++; if (pcOut !== 32'h10 || instructionValid !== 1'b1 || instructionOut !== 32'hB0) begin errors++; $display("FAIL load_resume got %h/%b/%h want 10/1/b0", pcOut, instructionValid, instructionOut); end
    tick(); #1;
    checks++; if (pcOut !== 32'h14 || instructionOut !== 32'hB1) begin errors++; $display("FAIL load_resume_next got %h/%h want 14/b1", pcOut, instructionOut); end
    tick();
    loadReq = 1'b1;
    #1;
    tick();
    loadAddress = 32'h80;
    loadData = 32'hC0;
    #1;
    checks++; if (memWriteEnable !== 1'b1) begin errors++; $display("FAIL load2_we got %b want 1", memWriteEnable); end
  endtask
`else
  task automatic test_loader();
    tick();
    loadReq = 1'b1;
    loadAddress = 32'h40;
    loadData = 32'hDEAD_BEEF;
    #1;
    checks++; if (pcOut !== 32'h4 || instructionValid !== 1'b1) begin errors++; $display("FAIL noload_pc got %h/%b want 4/1", pcOut, instructionValid); end
    checks++; if (loadGrant !== 1'b0 || memWriteEnable !== 1'b0) begin errors++; $display("FAIL noload_grant got %b/%b want 0/0", loadGrant, memWriteEnable); end
    checks++; if (memWriteData !== 32'h0 || memAddress !== 32'h2) begin errors++; $display("FAIL noload_port got %h/%h want 0/2", memWriteData, memAddress); end
    tick(); #1;
    checks++; if (pcOut !== 32'h8 || instructionOut !== 32'hA000_0002 || loadGrant !== 1'b0) begin errors++; $display("FAIL noload_next got %h/%h/%b want 8/a0000002/0", pcOut, instructionOut, loadGrant); end
  endtask
`endif

  task automatic test_reset_mid();
    #2;
    reset = 1'b0;
    #1;
    checks++; if (memWriteEnable !== 1'b0 || loadGrant !== 1'b0) begin errors++; $display("FAIL midrst_we got %b/%b want 0/0", memWriteEnable, loadGrant); end
    checks++; if (instructionValid !== 1'b0 || memAddress !== 32'h0) begin errors++; $display("FAIL midrst_out got %b/%h want 0/0", instructionValid, memAddress); end
    loadReq = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++; if (instructionValid !== 1'b0 || memAddress !== 32'h0) begin errors++; $display("FAIL midrst_boot got %b/%h want 0/0", instructionValid, memAddress); end
    tick(); #1;
    checks++; if (pcOut !== 32'h0 || instructionValid !== 1'b1 || memAddress !== 32'h1) begin errors++; $display("FAIL midrst_restart got %h/%b/%h want 0/1/1", pcOut, instructionValid, memAddress); end
    tick(); #1;
    checks++; if (pcOut !== 32'h4 || instructionOut !== 32'hA000_0001) begin errors++; $display("FAIL midrst_next got %h/%h want 4/a0000001", pcOut, instructionOut); end
  endtask

  initial begin
    reset = 1'b0;
    stall = 1'b0;
    redirectValid = 1'b0;
    redirectTarget = 32'h0;
    loadReq = 1'b0;
    loadAddress = 32'h0;
    loadData = 32'h0;
    test_reset();
    test_fetch();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_wrap();
    test_loader();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
